// File: rtl/ram_block_mover.sv
// Block copy / constant fill master for the 32K x 16 single-port data RAM.
// One read then one write per copied word; fill writes one word per cycle.
module ram_block_mover #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  state_t              state_q, state_d;
  logic                mode_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [ADDR_W:0]     rem_q;
  logic [DATA_W-1:0]   fill_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W-1:0]   last_addr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = S_DONE;
          end else if (mode) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ:  state_d = S_WRITE;
      S_WRITE: begin
        if (rem_q == CNT_ONE) begin
          state_d = S_DONE;
        end else if (mode_q) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ram_load comes straight from the state register so an async reset
  // removes the write enable without waiting for a clock edge.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    ram_load    = 1'b0;
    ram_address = last_addr_q;
    ram_in      = '0;
    case (state_q)
      S_READ: begin
        busy        = 1'b1;
        ram_address = src_q;
      end
      S_WRITE: begin
        busy        = 1'b1;
        ram_load    = 1'b1;
        ram_address = dst_q;
        ram_in      = mode_q ? fill_q : ram_out;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      fill_q      <= '0;
      count_q     <= '0;
      last_addr_q <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        mode_q  <= mode;
        src_q   <= src_addr;
        dst_q   <= dst_addr;
        rem_q   <= length;
        fill_q  <= fill_value;
        count_q <= '0;
      end
      if (state_q == S_WRITE) begin
        count_q <= count_q + CNT_ONE;
        src_q   <= src_q + ADDR_ONE;
        dst_q   <= dst_q + ADDR_ONE;
        rem_q   <= rem_q - CNT_ONE;
      end
      // Keeps the address bus steady once the transfer leaves READ/WRITE.
      if (state_q == S_READ || state_q == S_WRITE) begin
        last_addr_q <= ram_address;
      end
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_ram_block_mover.sv
// Bench for ram_block_mover: behavioural RAM model plus a write/done scoreboard.
module tb_ram_block_mover;

  logic        clock      = 1'b0;
  logic        reset_n    = 1'b1;
  logic        start      = 1'b0;
  logic        mode       = 1'b0;
  logic [14:0] src_addr   = '0;
  logic [14:0] dst_addr   = '0;
  logic [15:0] length     = '0;
  logic [15:0] fill_value = '0;
  logic        busy, done, ram_load;
  logic [15:0] count, ram_in;
  logic [14:0] ram_address;
  logic [15:0] ram_out;

  ram_block_mover #(.ADDR_W(15), .DATA_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .busy(busy), .done(done), .count(count),
    .ram_address(ram_address), .ram_load(ram_load), .ram_in(ram_in),
    .ram_out(ram_out)
  );

  always #5 clock = ~clock;

  // RAM model with a bench-side preload port used only while the DUT is idle
  logic [15:0] mem [0:32767];
  logic        tb_we = 1'b0;
  logic [14:0] tb_wa = '0;
  logic [15:0] tb_wd = '0;

  always @(posedge clock) begin
    if (tb_we) mem[tb_wa] <= tb_wd;
    else if (ram_load) mem[ram_address] <= ram_in;
    else ram_out <= mem[ram_address];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [14:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic [15:0] cnt; int at_cyc; int busy_cycles; } dn_t;
  wr_t exp_wq[$];
  dn_t exp_dq[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_seen = 0;
  int busy_run = 0;
  wr_t mon_w;
  dn_t mon_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Monitor: compares every RAM write and every done pulse against the queues
  always @(negedge clock) begin
    if (!reset_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (ram_load) begin
        if (exp_wq.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write", ram_address, ram_in);
        end else begin
          mon_w = exp_wq.pop_front();
          check("write", {1'b0, ram_address, ram_in}, {1'b0, mon_w.addr, mon_w.data});
        end
      end
      if (done) begin
        done_seen++;
        if (exp_dq.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
        end else begin
          mon_d = exp_dq.pop_front();
          check("done_count", {16'h0, count}, {16'h0, mon_d.cnt});
          check("done_cycle", cyc, mon_d.at_cyc);
          check("done_busy_cycles", busy_run, mon_d.busy_cycles);
          $display("transfer done: count=%0d cycle=%0d busy_cycles=%0d", count, cyc, busy_run);
        end
        busy_run = 0;
      end
    end
  end

  task automatic poke(input logic [14:0] a, input logic [15:0] d);
    @(negedge clock);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clock);
    #1 tb_we = 1'b0;
  endtask

  task automatic push_wr(input logic [14:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    exp_wq.push_back(w);
  endtask

  // lat: cycles from the period after the start edge to the done cycle
  task automatic do_start(input logic m, input logic [14:0] s, input logic [14:0] d,
                          input logic [15:0] len, input logic [15:0] fv,
                          input bit exp_done, input int lat, input int bcyc);
    dn_t r;
    @(negedge clock);
    mode = m; src_addr = s; dst_addr = d; length = len; fill_value = fv; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    if (exp_done) begin
      r.cnt = len; r.at_cyc = cyc + lat; r.busy_cycles = bcyc;
      exp_dq.push_back(r);
    end
    // Scrambled inputs must not affect the running transfer
    mode = ~m; src_addr = 15'h7ABC; dst_addr = 15'h0ABC; length = 16'h0005; fill_value = 16'hDEAD;
    $display("transfer start: mode=%0d src=%h dst=%h len=%0d", m, s, d, len);
  endtask

  task automatic wait_done(input int max_cycles);
    int base;
    base = done_seen;
    for (int i = 0; i < max_cycles; i++) begin
      if (done_seen > base) break;
      @(posedge clock);
    end
    if (done_seen == base) begin
      total_cnt++;
      $display("FAIL done_timeout: got no done in %0d cycles, required one", max_cycles);
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bad;
    #3 reset_n = 1'b0;
    #4;
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_done", {31'h0, done}, 0);
    check("rst_ram_load", {31'h0, ram_load}, 0);
    check("rst_ram_address", {17'h0, ram_address}, 0);
    check("rst_ram_in", {16'h0, ram_in}, 0);
    check("rst_count", {16'h0, count}, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Copy basic
    poke(15'h0100, 16'h1111); poke(15'h0101, 16'h2222);
    poke(15'h0102, 16'h3333); poke(15'h0103, 16'h4444);
    push_wr(15'h0200, 16'h1111); push_wr(15'h0201, 16'h2222);
    push_wr(15'h0202, 16'h3333); push_wr(15'h0203, 16'h4444);
    do_start(1'b0, 15'h0100, 15'h0200, 16'd4, 16'h0000, 1'b1, 8, 8);
    wait_done(50);
    check("copy_count", {16'h0, count}, 4);
    check("copy_dst0", {16'h0, mem[15'h0200]}, 32'h1111);
    check("copy_dst3", {16'h0, mem[15'h0203]}, 32'h4444);
    check("copy_src1", {16'h0, mem[15'h0101]}, 32'h2222);
    check("copy_queue_empty", exp_wq.size(), 0);

    // Fill with wrap
    poke(15'h0002, 16'h5A5A);
    push_wr(15'h7FFE, 16'hBEEF); push_wr(15'h7FFF, 16'hBEEF);
    push_wr(15'h0000, 16'hBEEF); push_wr(15'h0001, 16'hBEEF);
    do_start(1'b1, 15'h0000, 15'h7FFE, 16'd4, 16'hBEEF, 1'b1, 4, 4);
    wait_done(50);
    check("fill_7ffe", {16'h0, mem[15'h7FFE]}, 32'hBEEF);
    check("fill_7fff", {16'h0, mem[15'h7FFF]}, 32'hBEEF);
    check("fill_0000", {16'h0, mem[15'h0000]}, 32'hBEEF);
    check("fill_0001", {16'h0, mem[15'h0001]}, 32'hBEEF);
    check("fill_0002_kept", {16'h0, mem[15'h0002]}, 32'h5A5A);

    // Zero length
    do_start(1'b1, 15'h0000, 15'h0400, 16'd0, 16'h1234, 1'b1, 0, 0);
    wait_done(20);
    check("zero_count", {16'h0, count}, 0);

    // Start pulse while busy is ignored
    poke(15'h0300, 16'h00A0); poke(15'h0301, 16'h00A1);
    poke(15'h0302, 16'h00A2); poke(15'h0303, 16'h00A3);
    push_wr(15'h0310, 16'h00A0); push_wr(15'h0311, 16'h00A1);
    push_wr(15'h0312, 16'h00A2); push_wr(15'h0313, 16'h00A3);
    do_start(1'b0, 15'h0300, 15'h0310, 16'd4, 16'h0000, 1'b1, 8, 8);
    repeat (2) @(posedge clock);
    @(negedge clock);
    mode = 1'b1; dst_addr = 15'h0320; length = 16'd2; fill_value = 16'hCAFE; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(50);
    base = done_seen;
    repeat (6) @(posedge clock);
    #1;
    check("busy_start_queue_empty", exp_wq.size(), 0);
    check("busy_start_no_extra_done", done_seen, base);
    check("busy_start_count", {16'h0, count}, 4);

    // Reset mid-transfer after the third write
    for (int i = 0; i < 8; i++) poke(15'h0010 + 15'(i), 16'h5555);
    push_wr(15'h0010, 16'hAAAA); push_wr(15'h0011, 16'hAAAA); push_wr(15'h0012, 16'hAAAA);
    do_start(1'b1, 15'h0000, 15'h0010, 16'd8, 16'hAAAA, 1'b0, 0, 0);
    base = done_seen;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("abort_ram_load", {31'h0, ram_load}, 0);
    check("abort_busy", {31'h0, busy}, 0);
    check("abort_count", {16'h0, count}, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check("abort_no_done", done_seen, base);
    check("abort_queue_empty", exp_wq.size(), 0);
    check("abort_mem_0012", {16'h0, mem[15'h0012]}, 32'hAAAA);
    check("abort_mem_0013", {16'h0, mem[15'h0013]}, 32'h5555);
    check("abort_mem_0017", {16'h0, mem[15'h0017]}, 32'h5555);

    // Overlapping forward copy
    poke(15'h0050, 16'h00AB); poke(15'h0051, 16'h1111);
    poke(15'h0052, 16'h2222); poke(15'h0053, 16'h3333);
    push_wr(15'h0051, 16'h00AB); push_wr(15'h0052, 16'h00AB); push_wr(15'h0053, 16'h00AB);
    do_start(1'b0, 15'h0050, 15'h0051, 16'd3, 16'h0000, 1'b1, 6, 6);
    wait_done(40);
    check("overlap_0053", {16'h0, mem[15'h0053]}, 32'h00AB);
    check("overlap_0050", {16'h0, mem[15'h0050]}, 32'h00AB);

    // Full RAM clear from a non-zero base
    for (int i = 0; i < 32768; i++) push_wr(15'(32'h1234 + i), 16'h0000);
    do_start(1'b1, 15'h0000, 15'h1234, 16'h8000, 16'h0000, 1'b1, 32768, 32768);
    wait_done(33000);
    check("full_count", {16'h0, count}, 32'h8000);
    bad = 0;
    for (int i = 0; i < 32768; i++) if (mem[i] !== 16'h0000) bad++;
    check("full_nonzero_words", bad, 0);
    check("full_queue_empty", exp_wq.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
